// File: rtl/regfile_wr_arbiter.sv
// Three-requester register-file write arbiter with a full-file clear sequencer (x1..x31 <- 0).
// Define REGFILE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority req0 > req1 > req2.
module regfile_wr_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [4:0]   req0_addr,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [4:0]   req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  input  logic         req2_valid,
  input  logic [4:0]   req2_addr,
  input  logic [N-1:0] req2_data,
  output logic         req2_ready,
  input  logic         clr_start,
  output logic         w_en,
  output logic [4:0]   w_addr,
  output logic [N-1:0] w_data,
  output logic         busy,
  output logic         clr_done
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         w_en_q, w_en_d;
  logic [4:0]   w_addr_q, w_addr_d;
  logic [N-1:0] w_data_q, w_data_d;
  logic         busy_q, busy_d;
  logic         clr_done_q, clr_done_d;

  logic [2:0]   vld_s, gnt_s, rdy_s;
  logic [4:0]   sel_addr_s;
  logic [N-1:0] sel_data_s;
  logic [1:0]   sel_idx_s;

  assign vld_s = {req2_valid, req1_valid, req0_valid};

`ifdef REGFILE_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Round-robin pick: search begins one past the last granted requester.
  always_comb begin
    gnt_s = 3'b000;
    case (ptr_q)
      2'd0: begin
        if (vld_s[1])      gnt_s = 3'b010;
        else if (vld_s[2]) gnt_s = 3'b100;
        else if (vld_s[0]) gnt_s = 3'b001;
        else               gnt_s = 3'b000;
      end
      2'd1: begin
        if (vld_s[2])      gnt_s = 3'b100;
        else if (vld_s[0]) gnt_s = 3'b001;
        else if (vld_s[1]) gnt_s = 3'b010;
        else               gnt_s = 3'b000;
      end
      default: begin
        if (vld_s[0])      gnt_s = 3'b001;
        else if (vld_s[1]) gnt_s = 3'b010;
        else if (vld_s[2]) gnt_s = 3'b100;
        else               gnt_s = 3'b000;
      end
    endcase
  end
`else
  // Fixed-priority pick, req0 highest.
  always_comb begin
    gnt_s = 3'b000;
    if (vld_s[0])      gnt_s = 3'b001;
    else if (vld_s[1]) gnt_s = 3'b010;
    else if (vld_s[2]) gnt_s = 3'b100;
    else               gnt_s = 3'b000;
  end
`endif

  // Grants are only visible while idle; mux the winner's address and data.
  always_comb begin
    rdy_s      = (state_q == S_IDLE) ? gnt_s : 3'b000;
    sel_addr_s = 5'd0;
    sel_data_s = {N{1'b0}};
    sel_idx_s  = 2'd0;
    case (rdy_s)
      3'b001: begin sel_addr_s = req0_addr; sel_data_s = req0_data; sel_idx_s = 2'd0; end
      3'b010: begin sel_addr_s = req1_addr; sel_data_s = req1_data; sel_idx_s = 2'd1; end
      3'b100: begin sel_addr_s = req2_addr; sel_data_s = req2_data; sel_idx_s = 2'd2; end
      default: begin sel_addr_s = 5'd0; sel_data_s = {N{1'b0}}; sel_idx_s = 2'd0; end
    endcase
  end

  assign req0_ready = rdy_s[0];
  assign req1_ready = rdy_s[1];
  assign req2_ready = rdy_s[2];

  // Next-state and next-output logic for the IDLE/CLEAR controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    clr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A granted write to x0 is accepted but never reaches the file.
        if ((|rdy_s) && (sel_addr_s != 5'd0)) begin
          w_en_d   = 1'b1;
          w_addr_d = sel_addr_s;
          w_data_d = sel_data_s;
        end else begin
          w_en_d = 1'b0;
        end
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = 5'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_en_d   = 1'b1;
        w_addr_d = cnt_q;
        w_data_d = {N{1'b0}};
        if (cnt_q == 5'd31) begin
          state_d    = S_IDLE;
          cnt_d      = 5'd1;
          clr_done_d = 1'b1;
        end else begin
          state_d = S_CLEAR;
          cnt_d   = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd1;
      end
    endcase
    busy_d = (state_d == S_CLEAR);
  end

`ifdef REGFILE_ARB_RR_EN
  // Pointer remembers the last requester that actually transferred.
  always_comb begin
    if (|rdy_s) ptr_d = sel_idx_s;
    else        ptr_d = ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 2'd2;
    else      ptr_q <= ptr_d;
  end
`endif

  // Controller and write-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd1;
      w_en_q     <= 1'b0;
      w_addr_q   <= 5'd0;
      w_data_q   <= {N{1'b0}};
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign w_en     = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a negedge monitor predicts grants, busy and the
// write stream from a cycle-indexed model; the driver issues directed and random traffic.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic [4:0]  adr [3];
  logic [31:0] dat [3];
  logic        clr_start;
  wire  [2:0]  rdy;
  wire         w_en, busy, clr_done;
  wire  [4:0]  w_addr;
  wire  [31:0] w_data;

  regfile_wr_arbiter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(vld[0]), .req0_addr(adr[0]), .req0_data(dat[0]), .req0_ready(rdy[0]),
    .req1_valid(vld[1]), .req1_addr(adr[1]), .req1_data(dat[1]), .req1_ready(rdy[1]),
    .req2_valid(vld[2]), .req2_addr(adr[2]), .req2_data(dat[2]), .req2_ready(rdy[2]),
    .clr_start(clr_start),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .busy(busy), .clr_done(clr_done)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
    logic        done;
  } exp_t;

  exp_t       q [$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ptr = 2;
  int         clr_s = -1000;
  logic [2:0] fire = 3'b000;
  logic       final_chk = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input logic [2:0] v, input int p);
`ifdef REGFILE_ARB_RR_EN
    for (int i = 1; i <= 3; i++) begin
      if (v[(p + i) % 3]) return (p + i) % 3;
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor + reference model: everything is judged from the inputs seen each cycle.
  always @(negedge clk) begin
    exp_t       e;
    int         w;
    logic       busy_e;
    logic [2:0] rdy_e;
    if (!rst) begin
      chk("reset_outputs", {27'd0, w_en, busy, clr_done, w_addr, w_data}, 64'd0);
      q.delete();
      ptr   = 2;
      clr_s = -1000;
      fire  = 3'b000;
    end else begin
      busy_e = (cyc >= clr_s + 1) && (cyc <= clr_s + 31);
      if (w_en) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {27'd0, w_addr, w_data}, 64'd0 - 64'd1);
        end else begin
          e = q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
          chk("write_addr_data_done", {26'd0, w_addr, w_data, clr_done}, {26'd0, e.a, e.d, e.done});
        end
      end else begin
        chk("missing_write", {63'd0, (q.size() > 0 && q[0].cyc <= cyc)}, 64'd0);
        chk("clr_done_without_write", {63'd0, clr_done}, 64'd0);
      end
      chk("busy", {63'd0, busy}, {63'd0, busy_e});
      w     = busy_e ? -1 : pick(vld, ptr);
      rdy_e = (w < 0) ? 3'b000 : (3'b001 << w);
      chk("ready", {61'd0, rdy}, {61'd0, rdy_e});
      fire = rdy & vld;
      if (w >= 0) begin
        ptr = w;
        if (adr[w] != 5'd0) q.push_back('{cyc + 1, adr[w], dat[w], 1'b0});
      end
      if (!busy_e && clr_start) begin
        clr_s = cyc;
        for (int a = 1; a <= 31; a++) q.push_back('{cyc + 1 + a, 5'(a), 32'd0, (a == 31)});
      end
      if (final_chk) chk("queue_drained", 64'(q.size()), 64'd0);
    end
  end

  // Advance one cycle: retire transferred requests, optionally add random ones and clears.
  task automatic step(input bit rnd, input int clr_pct);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (fire[k]) vld[k] = 1'b0;
      if (rnd && !vld[k] && $urandom_range(0, 2) != 0) begin
        vld[k] = 1'b1;
        adr[k] = 5'($urandom_range(0, 31));
        dat[k] = $urandom;
      end
    end
    clr_start = (clr_pct > 0) && ($urandom_range(0, 99) < clr_pct);
  endtask

  initial begin
    rst       = 1'b0;
    vld       = 3'b000;
    clr_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = 5'd0;
      dat[k] = 32'd0;
    end
    // First cycle after reset: req0 write to x5.
    vld[0] = 1'b1;
    adr[0] = 5'd5;
    dat[0] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // Write to x0 from req1 is accepted and dropped.
    step(1'b0, 0);
    vld[1] = 1'b1;
    adr[1] = 5'd0;
    dat[1] = 32'h0000_1234;
    // Clear requested together with a req2 write; clr_start re-asserted mid-clear.
    step(1'b0, 0);
    vld[2]    = 1'b1;
    adr[2]    = 5'd7;
    dat[2]    = 32'hA5A5_0707;
    clr_start = 1'b1;
    for (int i = 0; i < 36; i++) step(1'b0, (i >= 3 && i < 10) ? 100 : 0);
    // All three requesters valid continuously.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0);
      for (int k = 0; k < 3; k++) begin
        if (!vld[k]) begin
          vld[k] = 1'b1;
          adr[k] = 5'($urandom_range(1, 31));
          dat[k] = $urandom;
        end
      end
    end
    for (int i = 0; i < 600; i++) step(1'b1, 2);
    for (int i = 0; i < 40; i++) step(1'b0, 0);
    // Clear pulse, then reset lands while clear address 10 is on the outputs.
    clr_start = 1'b1;
    for (int i = 0; i < 11; i++) step(1'b0, 0);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b1, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 0);
    final_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 final_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter: N, 32, data width of every write-data path.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: reqK_valid  input  1  requester K write request, K=0..2.
REQ-005 SHALL have ports: reqK_addr  input  5  requester K destination register.
REQ-006 SHALL have ports: reqK_data  input  N  requester K write data.
REQ-007 SHALL have ports: reqK_ready  output  1  requester K granted this cycle.
REQ-008 SHALL have port: clr_start  input  1  request a full register-file clear.
REQ-009 SHALL have ports: w_en  output  1, w_addr  output  5, w_data  output  N; register-file write port, all registered.
REQ-010 SHALL have ports: busy  output  1  clear in progress; clr_done  output  1  one-cycle clear-complete pulse.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-012 In IDLE, SHALL grant at most one valid requester per cycle; reqK_ready SHALL be combinational: asserted only when state is IDLE and K is the selected grant.
REQ-013 In CLEAR, every reqK_ready SHALL be 0, regardless of valid.
REQ-014 A transfer occurs when reqK_valid and reqK_ready are both 1 in the same cycle; the requester holds valid, addr and data stable until transfer.
REQ-015 On a transfer, SHALL drive w_en=1, w_addr=reqK_addr, w_data=reqK_data in the next cycle (latency 1).
REQ-016 With no transfer and state IDLE, w_en SHALL be 0 in the next cycle; w_addr and w_data hold their previous values.
REQ-017 A transfer with reqK_addr=0 SHALL be accepted (ready=1), and the next cycle SHALL have w_en=0 (write to x0 dropped).
REQ-018 In IDLE with clr_start=1, SHALL move to CLEAR on the next edge with the clear counter at 1; a request granted in that same cycle still completes, and its write precedes the clear writes.
REQ-019 In each CLEAR cycle, SHALL load w_en=1, w_addr=counter, w_data=0, then increment the counter; after loading address 31, SHALL return to IDLE (31 writes, addresses 1..31 ascending).
REQ-020 clr_done SHALL be 1 in exactly the cycle in which w_addr=31 with w_en=1 is presented on the outputs from the clear, and 0 otherwise.
REQ-021 busy SHALL be 1 exactly while state is CLEAR.
REQ-022 clr_start while in CLEAR SHALL be ignored; no restart and no queued clear.
REQ-023 The counter SHALL be 5 bits and SHALL never load address 0.

Reset
REQ-024 While rst=0, SHALL force: state IDLE, w_en=0, w_addr=0, w_data=0, busy=0, clr_done=0, clear counter=1, round-robin pointer=2.
REQ-025 rst asserted mid-CLEAR SHALL abort the clear immediately; no clr_done is produced.
REQ-026 After rst releases, the first cycle SHALL be able to grant a request (no dead cycle).

Configuration
REQ-027 Macro REGFILE_ARB_RR_EN defined: round-robin arbitration; the search starts at pointer+1 mod 3; the pointer updates to K only on a transfer from K.
REQ-028 Macro REGFILE_ARB_RR_EN undefined: fixed priority req0 > req1 > req2; no pointer state is built.
REQ-029 With either setting, grant after reset SHALL favour req0 (RR pointer reset value is 2).

Verification
REQ-030 Reset, then req0 valid with addr=5, data=0xDEADBEEF -> req0_ready=1 in the same cycle; next cycle w_en=1, w_addr=5, w_data=0xDEADBEEF.
REQ-031 RR build, all three valid continuously -> grants 0,1,2,0,1,2; fixed build -> req0 granted every cycle, req1 and req2 starved.
REQ-032 req1 valid with addr=0, data=0x1234 -> req1_ready=1; next cycle w_en=0.
REQ-033 clr_start pulse in IDLE -> busy for 31 cycles; w_addr steps 1..31 with w_data=0 and w_en=1; clr_done=1 only with w_addr=31; all readies 0 throughout.
REQ-034 rst=0 asserted at clear address 10 -> all outputs are reset values asynchronously; after release, no further clear writes occur and clr_done never pulses.
REQ-035 clr_start and req2 valid (addr=7) in the same IDLE cycle -> req2 write is output first, then the 31 clear writes; clr_start re-asserted during CLEAR has no effect.
